regfile_read_arbiter: RTL

Round-robin arbiter that shares the single 64-bit, 32-entry register-file read port (5-bit select in, 64-bit data out) among NUM_REQ requesters. Each requester presents a register address with a valid/ready handshake. The arbiter drives the port select, captures the selected 64-bit word, and returns it to the granted requester one cycle later. Responses use a one-entry hold with per-requester backpressure. The block sits between the decode/operand-fetch stage agents and the register-file read mux.

---
 rtl/regfile_read_arbiter.sv | 121 ++++++++++++
 1 files changed

// File: rtl/regfile_read_arbiter.sv
// regfile_read_arbiter
//
// Round-robin arbiter that lets NUM_REQ requesters share one register-file
// read port. Each cycle at most one pending request is granted. The granted
// address drives the read-mux select, and the returned word is captured.
// One cycle later that word is presented to the winner through a one-entry
// response hold, which waits for the owner to accept it.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-high reset
//   req_valid  per-requester request valid
//   req_addr   packed register indices, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_ready  one-hot grant, combinational, asserted in the acceptance cycle
//   rf_sel     select to the register-file read mux (0 when nothing is granted)
//   rf_data    read-mux output, combinational from rf_sel
//   rsp_valid  one-hot response valid, registered
//   rsp_data   registered read data
//   rsp_ready  per-requester response accept (only the owner's bit is used)

module regfile_read_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [ADDR_WIDTH-1:0]         rf_sel,
    input  logic [DATA_WIDTH-1:0]         rf_data,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    input  logic [NUM_REQ-1:0]            rsp_ready
);

    localparam int unsigned IdxW = $clog2(NUM_REQ);

    typedef enum logic {StIdle, StHold} state_e;

    state_e                  state_q;
    logic [IdxW-1:0]         rr_ptr_q;
    logic [IdxW-1:0]         owner_q;
    logic [NUM_REQ-1:0]      rsp_valid_q;
    logic [DATA_WIDTH-1:0]   rsp_data_q;

    logic                    can_grant;
    logic                    found;
    logic                    grant;
    int unsigned             scan_idx;
    logic [IdxW-1:0]         win;
    logic [IdxW-1:0]         rr_ptr_next;

    // The port is free when nothing is held, or when the held response is
    // being accepted this very cycle (simultaneous accept and grant).
    always_comb begin
        can_grant = 1'b0;
        if (!reset) begin
            if (state_q == StIdle) begin
                can_grant = 1'b1;
            end else begin
                can_grant = rsp_ready[owner_q];
            end
        end
    end

    // Scan from rr_ptr upward, wrapping, and take the first valid requester.
    always_comb begin
        found    = 1'b0;
        win      = '0;
        scan_idx = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            scan_idx = (32'(rr_ptr_q) + k) % NUM_REQ;
            if (!found && req_valid[scan_idx]) begin
                found = 1'b1;
                win   = IdxW'(scan_idx);
            end
        end
    end

    always_comb begin
        grant       = can_grant && found;
        req_ready   = '0;
        rf_sel      = '0;
        rr_ptr_next = rr_ptr_q;
        if (grant) begin
            req_ready = NUM_REQ'(1) << win;
            rf_sel    = req_addr[win*ADDR_WIDTH +: ADDR_WIDTH];
            if (32'(win) == NUM_REQ - 1) begin
                rr_ptr_next = '0;
            end else begin
                rr_ptr_next = win + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else if (grant) begin
            state_q     <= StHold;
            rr_ptr_q    <= rr_ptr_next;
            owner_q     <= win;
            rsp_valid_q <= req_ready;
            rsp_data_q  <= rf_data;
        end else if (state_q == StHold && rsp_ready[owner_q]) begin
            // Accepted with nothing pending: drop valid, keep the last data.
            state_q     <= StIdle;
            rsp_valid_q <= '0;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

endmodule
